// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LD  = 3'b011,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101,
    LD_LWU = 3'b110
  } load_funct3_e;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010,
    ST_SD = 3'b011
  } store_funct3_e;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_t;

  // log2 of the access size in bytes; funct3[2] only selects zero-extension
  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  function automatic logic funct3_legal(input logic       is_load,
                                        input logic [2:0] funct3,
                                        input logic       is_rv64);
    logic legal;
    legal = 1'b0;
    if (is_load) begin
      case (funct3)
        LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: legal = 1'b1;
        LD_LD, LD_LWU:                       legal = is_rv64;
        default:                             legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        ST_SB, ST_SH, ST_SW: legal = 1'b1;
        ST_SD:               legal = is_rv64;
        default:             legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: byte enables, store lane shift, load extraction and extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  st_data,
  input  logic [XLEN-1:0]  rd_data,
  output logic [NB-1:0]    mbe,
  output logic [XLEN-1:0]  st_lanes,
  output logic [XLEN-1:0]  ld_result
);

  logic [1:0]              size;
  logic [NB-1:0]           base_mask;
  logic [$clog2(XLEN)-1:0] bit_off;
  logic [XLEN-1:0]         ld_shifted;

  assign size    = access_size(funct3);
  assign bit_off = {offset, 3'b000};

  always_comb begin
    base_mask = '0;
    for (int i = 0; i < NB; i++) begin
      base_mask[i] = (i < (1 << size));
    end
  end

  assign mbe        = base_mask << offset;
  assign st_lanes   = st_data << bit_off;
  assign ld_shifted = rd_data >> bit_off;

  always_comb begin
    ld_result = ld_shifted;
    case (funct3)
      LD_LB:   ld_result = XLEN'($signed(ld_shifted[7:0]));
      LD_LH:   ld_result = XLEN'($signed(ld_shifted[15:0]));
      LD_LW:   ld_result = XLEN'($signed(ld_shifted[31:0]));
      LD_LBU:  ld_result = XLEN'(ld_shifted[7:0]);
      LD_LHU:  ld_result = XLEN'(ld_shifted[15:0]);
      LD_LWU:  ld_result = XLEN'(ld_shifted[31:0]);
      default: ld_result = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one request from EX/MEM, runs the
// data-memory handshake while stalling the pipe, and registers the load result.
//
//   state | meaning
//   IDLE  | no transaction; a legal aligned request is latched here
//   BUSY  | strobes held from the latched request until data_resp
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_load,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  input  logic                flush,
  output logic                stall,
  output logic                data_read,
  output logic                data_write,
  output logic [XLEN/8-1:0]   data_mbe,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [XLEN-1:0]     data_wdata,
  input  logic                data_resp,
  input  logic [XLEN-1:0]     data_rdata,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                misalign
);

  localparam int   NB      = XLEN / 8;
  localparam int   OFF_W   = $clog2(NB);
  localparam logic IS_RV64 = (XLEN == 64);

  lsu_state_t        state_q, state_d;
  logic              load_q, load_d;
  logic              kill_q, kill_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              misalign_q, misalign_d;

  logic              req_legal;
  logic              req_aligned;
  logic [2:0]        size_mask;
  logic              stall_c;
  logic              busy;
  logic [NB-1:0]     mbe_c;
  logic [XLEN-1:0]   st_lanes_c;
  logic [XLEN-1:0]   ld_result_c;

  assign req_legal   = funct3_legal(req_load, req_funct3, IS_RV64);
  assign size_mask   = 3'((4'd1 << access_size(req_funct3)) - 4'd1);
  assign req_aligned = ((req_addr[2:0] & size_mask) == 3'b000);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (funct3_q),
    .offset    (addr_q[OFF_W-1:0]),
    .st_data   (wdata_q),
    .rd_data   (data_rdata),
    .mbe       (mbe_c),
    .st_lanes  (st_lanes_c),
    .ld_result (ld_result_c)
  );

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    kill_d     = kill_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid && !flush) begin
          if (req_legal && req_aligned) begin
            state_d  = LSU_BUSY;
            load_d   = req_load;
            kill_d   = 1'b0;
            funct3_d = req_funct3;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            rd_d     = req_rd;
            stall_c  = 1'b1;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      LSU_BUSY: begin
        // a flushed transaction still finishes on the bus; only writeback is dropped
        if (flush) kill_d = 1'b1;
        if (data_resp) begin
          state_d = LSU_IDLE;
          if (load_q && !kill_q && !flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ld_result_c;
          end
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LSU_IDLE;
      load_q     <= 1'b0;
      kill_q     <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      kill_q     <= kill_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign busy       = (state_q == LSU_BUSY);
  // gated by reset so the stall path is quiet while the core is held in reset
  assign stall      = stall_c & rst;
  assign data_read  = busy & load_q;
  assign data_write = busy & ~load_q;
  assign data_addr  = busy ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
  assign data_mbe   = busy ? mbe_c : '0;
  assign data_wdata = (busy && !load_q) ? st_lanes_c : '0;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit, exercising an XLEN=32 and an XLEN=64 instance.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_load = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        data_resp = 1'b0;
  logic [63:0] data_rdata = '0;

  logic        stall32, rd32, wr32, wbv32, mis32;
  logic [3:0]  mbe32;
  logic [31:0] addr32, wdata32, wbd32;
  logic [4:0]  wbrd32;
  logic        stall64, rd64, wr64, wbv64, mis64;
  logic [7:0]  mbe64;
  logic [31:0] addr64;
  logic [63:0] wdata64, wbd64;
  logic [4:0]  wbrd64;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .req_rd(req_rd), .flush(flush), .stall(stall32), .data_read(rd32),
    .data_write(wr32), .data_mbe(mbe32), .data_addr(addr32), .data_wdata(wdata32),
    .data_resp(data_resp), .data_rdata(data_rdata[31:0]), .wb_valid(wbv32),
    .wb_rd(wbrd32), .wb_data(wbd32), .misalign(mis32)
  );

  load_store_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .flush(flush), .stall(stall64), .data_read(rd64),
    .data_write(wr64), .data_mbe(mbe64), .data_addr(addr64), .data_wdata(wdata64),
    .data_resp(data_resp), .data_rdata(data_rdata), .wb_valid(wbv64),
    .wb_rd(wbrd64), .wb_data(wbd64), .misalign(mis64)
  );

  logic        o_stall, o_read, o_write, o_wb_valid, o_misalign;
  logic [7:0]  o_mbe;
  logic [31:0] o_addr;
  logic [63:0] o_wdata, o_wb_data;
  logic [4:0]  o_wb_rd;

  assign o_stall    = sel ? stall64 : stall32;
  assign o_read     = sel ? rd64 : rd32;
  assign o_write    = sel ? wr64 : wr32;
  assign o_wb_valid = sel ? wbv64 : wbv32;
  assign o_misalign = sel ? mis64 : mis32;
  assign o_mbe      = sel ? mbe64 : {4'b0, mbe32};
  assign o_addr     = sel ? addr64 : addr32;
  assign o_wdata    = sel ? wdata64 : {32'b0, wdata32};
  assign o_wb_data  = sel ? wbd64 : {32'b0, wbd32};
  assign o_wb_rd    = sel ? wbrd64 : wbrd32;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input int xl, input logic [2:0] f3,
                                             input int off, input logic [63:0] rdat);
    logic [63:0] v;
    int nb;
    v  = '0;
    nb = 1 << f3[1:0];
    for (int i = 0; i < nb; i++) v[i*8 +: 8] = rdat[(off+i)*8 +: 8];
    if (!f3[2] && nb < xl/8 && v[nb*8-1])
      for (int i = nb*8; i < xl; i++) v[i] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst && o_wb_valid) begin
      chk("wb_sb_nonempty", (sb_q.size() > 0), 1'b1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wb_data", o_wb_data, e.data);
        chk("wb_rd", o_wb_rd, e.rd);
      end
    end
  end

  task automatic do_access(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [63:0] wd, input logic [4:0] rd, input logic [63:0] rdat,
                           input int delay, input int flush_at, input logic flush_resp);
    int xl, nb, off, stall_cnt;
    logic [7:0]  exp_mbe;
    logic [63:0] w, exp_wd;
    logic        exp_wb;
    xl  = sel ? 64 : 32;
    nb  = 1 << f3[1:0];
    off = int'(addr) & (xl/8 - 1);
    exp_mbe = '0;
    for (int i = 0; i < nb; i++) exp_mbe[off+i] = 1'b1;
    w = (xl == 32) ? {32'b0, wd[31:0]} : wd;
    exp_wd = w << (8*off);
    if (xl == 32) exp_wd[63:32] = '0;
    exp_wb = ld && (flush_at < 0) && !flush_resp;
    if (exp_wb) sb_q.push_back('{data: model_load(xl, f3, off, rdat), rd: rd});

    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_rd = rd;
    #1 chk("accept_stall", o_stall, 1'b1);
    stall_cnt = 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    for (int k = 0; k <= delay; k++) begin
      if (k > 0) @(negedge clk);
      flush      = (k == flush_at) || (k == delay && flush_resp);
      data_resp  = (k == delay);
      data_rdata = (k == delay) ? rdat : {$urandom, $urandom};
      #1;
      chk("read_strobe", o_read, ld);
      chk("write_strobe", o_write, !ld);
      chk("data_addr", o_addr, addr & ~(32'(xl/8) - 32'd1));
      chk("data_mbe", o_mbe, exp_mbe);
      if (!ld) chk("data_wdata", o_wdata, exp_wd);
      if (o_stall) stall_cnt++;
    end
    @(negedge clk);
    data_resp = 1'b0;
    flush     = 1'b0;
    chk("stall_cycles", stall_cnt, 1 + delay);
    chk("wb_valid", o_wb_valid, exp_wb);
    chk("strobes_drop", o_read | o_write, 1'b0);
  endtask

  task automatic do_reject(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic with_flush);
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = addr; flush = with_flush;
    #1 chk("reject_stall", o_stall, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("misalign_pulse", o_misalign, !with_flush);
    chk("reject_no_strobe", o_read | o_write, 1'b0);
    @(negedge clk);
    chk("misalign_end", o_misalign, 1'b0);
  endtask

  task automatic do_random(input int n);
    logic [2:0] f3;
    logic       ld;
    int         nb;
    for (int i = 0; i < n; i++) begin
      ld = 1'($urandom_range(0, 1));
      if (ld) begin
        case ($urandom_range(0, sel ? 6 : 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
          4: f3 = 3'b101; 5: f3 = 3'b011; default: f3 = 3'b110;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, sel ? 3 : 2));
      end
      nb = 1 << f3[1:0];
      do_access(ld, f3, $urandom & 32'h0000_FFFF & ~(32'(nb) - 32'd1),
                {$urandom, $urandom}, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                $urandom_range(0, 2), -1, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100;
    #23;
    chk("rst_ctrl32", {stall32, rd32, wr32, wbv32, mis32}, '0);
    chk("rst_ctrl64", {stall64, rd64, wr64, wbv64, mis64}, '0);
    chk("rst_bus32", {addr32, mbe32, wdata32, wbd32, wbrd32}, '0);
    chk("rst_bus64", {mbe64, wdata64, wbd64}, '0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;

    sel = 1'b0;
    do_access(1'b0, 3'b010, 32'h104, 64'hDEADBEEF, 5'd0, 64'h0, 3, -1, 1'b0);
    do_access(1'b0, 3'b000, 32'h203, 64'h000000AB, 5'd0, 64'h0, 1, -1, 1'b0);
    do_access(1'b1, 3'b000, 32'h102, 64'h0, 5'd5, 64'h00800000, 0, -1, 1'b0);
    chk("lb_value", model_load(32, 3'b000, 2, 64'h00800000), 64'hFFFFFF80);
    do_access(1'b1, 3'b100, 32'h102, 64'h0, 5'd6, 64'h00800000, 0, -1, 1'b0);
    do_access(1'b1, 3'b001, 32'h106, 64'h0, 5'd7, 64'h8001_0000, 1, -1, 1'b0);
    do_reject(1'b1, 3'b001, 32'h103, 1'b0);
    do_reject(1'b1, 3'b011, 32'h100, 1'b0);
    do_reject(1'b0, 3'b011, 32'h100, 1'b0);
    do_reject(1'b0, 3'b010, 32'h102, 1'b0);
    do_reject(1'b1, 3'b010, 32'h100, 1'b1);
    do_access(1'b1, 3'b010, 32'h300, 64'h0, 5'd9, 64'h12345678, 2, 1, 1'b0);
    do_access(1'b1, 3'b010, 32'h304, 64'h0, 5'd10, 64'h87654321, 0, -1, 1'b1);
    do_access(1'b0, 3'b001, 32'h306, 64'h0000BEEF, 5'd0, 64'h0, 2, 0, 1'b0);
    do_random(12);

    sel = 1'b1;
    do_access(1'b1, 3'b110, 32'h4, 64'h0, 5'd11, 64'h89ABCDEF_00000000, 0, -1, 1'b0);
    do_access(1'b1, 3'b010, 32'h4, 64'h0, 5'd12, 64'h89ABCDEF_00000000, 1, -1, 1'b0);
    do_access(1'b1, 3'b011, 32'h8, 64'h0, 5'd13, 64'hFEDCBA98_76543210, 0, -1, 1'b0);
    do_access(1'b0, 3'b011, 32'h10, 64'h01234567_89ABCDEF, 5'd0, 64'h0, 1, -1, 1'b0);
    do_access(1'b0, 3'b001, 32'h16, 64'h0000_0000_0000_C0DE, 5'd0, 64'h0, 0, -1, 1'b0);
    do_reject(1'b1, 3'b011, 32'h104, 1'b0);
    do_reject(1'b1, 3'b111, 32'h100, 1'b0);
    do_random(12);

    // reset taken in the middle of a transaction
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("pre_rst_busy", o_read, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {o_stall, o_read, o_write, o_wb_valid, o_misalign}, '0);
    chk("mid_rst_bus", {o_addr, o_mbe, o_wdata, o_wb_data}, '0);
    @(negedge clk);
    rst = 1'b1;
    data_resp = 1'b1;
    @(negedge clk);
    data_resp = 1'b0;
    chk("post_rst_idle", {o_read, o_write, o_wb_valid}, '0);
    do_access(1'b1, 3'b101, 32'h402, 64'h0, 5'd4, 64'hF00D_0000, 0, -1, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
